// File: rtl/gpr_writeback_nlane.sv
// N-lane writeback stage owning the GPR file: per-lane source select, load-hold
// capture across interlock, youngest-lane-wins conflict resolution, and bypassed read ports.

module gpr_wb_lane #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            interlock,
  input  logic            ex_wen,
  input  logic [RW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_wen,
  input  logic            mem_load,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] mem_doutb,
  output logic            wen,
  output logic [RW-1:0]   rd,
  output logic [XLEN-1:0] data
);
  logic            hold_vld;
  logic [XLEN-1:0] hold;

  // BRAM data is only valid on the first stalled cycle; freeze it until release.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_vld <= 1'b0;
      hold     <= '0;
    end else if (!interlock) begin
      hold_vld <= 1'b0;
    end else if (mem_load && !hold_vld) begin
      hold     <= mem_doutb;
      hold_vld <= 1'b1;
    end
  end

  always_comb begin
    wen  = 1'b0;
    rd   = ex_rd;
    data = ex_data;
    if (mem_load) begin
      wen  = 1'b1;
      rd   = mem_rd;
      data = hold_vld ? hold : mem_doutb;
    end else if (mem_wen) begin
      wen  = 1'b1;
      rd   = mem_rd;
      data = mem_data;
    end else if (ex_wen) begin
      wen  = 1'b1;
    end
  end
endmodule

module gpr_writeback_nlane #(
  parameter int LANES      = 2,
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int NRP        = 4,
  parameter int ZERO_REG   = 1,
  parameter int WR_THROUGH = 1,
  localparam int RW        = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  interlock,
  input  logic [LANES-1:0]      ex_wen,
  input  logic [LANES*RW-1:0]   ex_rd,
  input  logic [LANES*XLEN-1:0] ex_data,
  input  logic [LANES-1:0]      mem_wen,
  input  logic [LANES-1:0]      mem_load,
  input  logic [LANES*RW-1:0]   mem_rd,
  input  logic [LANES*XLEN-1:0] mem_data,
  input  logic [LANES*XLEN-1:0] mem_doutb,
  input  logic [NRP*RW-1:0]     rd_addr,
  output logic [NRP*XLEN-1:0]   rd_data,
  output logic [LANES-1:0]      wb_wen,
  output logic [LANES*RW-1:0]   wb_rd,
  output logic [LANES*XLEN-1:0] wb_data
);
  logic [NREG-1:0][XLEN-1:0]  regs;
  logic [LANES-1:0]           lane_wen;
  logic [LANES-1:0][RW-1:0]   lane_rd;
  logic [LANES-1:0][XLEN-1:0] lane_data;
  logic [LANES-1:0]           wen_eff;
  logic [LANES-1:0]           win;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gpr_wb_lane #(.XLEN(XLEN), .RW(RW)) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .interlock (interlock),
      .ex_wen    (ex_wen[i]),
      .ex_rd     (ex_rd[i*RW +: RW]),
      .ex_data   (ex_data[i*XLEN +: XLEN]),
      .mem_wen   (mem_wen[i]),
      .mem_load  (mem_load[i]),
      .mem_rd    (mem_rd[i*RW +: RW]),
      .mem_data  (mem_data[i*XLEN +: XLEN]),
      .mem_doutb (mem_doutb[i*XLEN +: XLEN]),
      .wen       (lane_wen[i]),
      .rd        (lane_rd[i]),
      .data      (lane_data[i])
    );
  end

  // Younger (higher-index) lane to the same rd squashes the older write.
  always_comb begin
    wen_eff = '0;
    win     = '0;
    for (int i = 0; i < LANES; i++)
      wen_eff[i] = lane_wen[i] && !((ZERO_REG != 0) && (lane_rd[i] == '0));
    for (int i = 0; i < LANES; i++) begin
      win[i] = wen_eff[i];
      for (int j = i + 1; j < LANES; j++)
        if (wen_eff[j] && (lane_rd[j] == lane_rd[i])) win[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      regs    <= '0;
      wb_wen  <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (interlock) begin
      wb_wen <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (win[i]) regs[lane_rd[i]] <= lane_data[i];
      wb_wen  <= win;
      wb_rd   <= lane_rd;
      wb_data <= lane_data;
    end
  end

  always_comb begin
    logic [RW-1:0] a;
    rd_data = '0;
    a       = '0;
    for (int p = 0; p < NRP; p++) begin
      a = rd_addr[p*RW +: RW];
      rd_data[p*XLEN +: XLEN] = ((ZERO_REG != 0) && (a == '0)) ? '0 : regs[a];
      if ((WR_THROUGH != 0) && !interlock)
        for (int i = 0; i < LANES; i++)
          if (win[i] && (lane_rd[i] == a)) rd_data[p*XLEN +: XLEN] = lane_data[i];
    end
  end
endmodule

// File: tb/tb_gpr_writeback_nlane.sv
// Directed checks for gpr_writeback_nlane with hand-computed expectations.

module tb_gpr_writeback_nlane;
  localparam int LANES = 2, XLEN = 32, NREG = 32, NRP = 4, RW = 5;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  interlock;
  logic [LANES-1:0]      ex_wen, mem_wen, mem_load;
  logic [LANES*RW-1:0]   ex_rd, mem_rd;
  logic [LANES*XLEN-1:0] ex_data, mem_data, mem_doutb;
  logic [NRP*RW-1:0]     rd_addr;
  logic [NRP*XLEN-1:0]   rd_data;
  logic [LANES-1:0]      wb_wen;
  logic [LANES*RW-1:0]   wb_rd;
  logic [LANES*XLEN-1:0] wb_data;

  int total = 0;
  int fails = 0;

  gpr_writeback_nlane #(.LANES(LANES), .XLEN(XLEN), .NREG(NREG), .NRP(NRP),
                        .ZERO_REG(1), .WR_THROUGH(1)) dut (
    .clk(clk), .rstn(rstn), .interlock(interlock),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_wen(mem_wen), .mem_load(mem_load), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_doutb(mem_doutb),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ex_wen = '0; mem_wen = '0; mem_load = '0;
    ex_rd = '0; mem_rd = '0;
    ex_data = '0; mem_data = '0; mem_doutb = '0;
  endtask

  task automatic rd0(input logic [RW-1:0] a, output logic [31:0] d);
    rd_addr[0 +: RW] = a;
    #1;
    d = rd_data[0 +: XLEN];
  endtask

  initial begin
    logic [31:0] d;
    rstn = 1'b0; interlock = 1'b0; rd_addr = '0;
    clr();
    tick(); tick();
    rstn = 1'b1;
    #1;

    // 1) reset state
    chk("reset_wb_wen", {30'd0, wb_wen}, 32'h0);
    for (int a = 0; a < NREG; a += NRP) begin
      for (int p = 0; p < NRP; p++) rd_addr[p*RW +: RW] = RW'(a + p);
      #1;
      for (int p = 0; p < NRP; p++)
        chk($sformatf("reset_reg%0d", a + p), rd_data[p*XLEN +: XLEN], 32'h0);
    end

    // 2) same rd in both lanes: lane1 wins
    ex_wen = 2'b11;
    ex_rd[0 +: RW] = 5'd5;  ex_data[0 +: XLEN] = 32'h11;
    ex_rd[RW +: RW] = 5'd5; ex_data[XLEN +: XLEN] = 32'h22;
    rd0(5'd5, d); chk("conflict_bypass", d, 32'h22);
    tick(); clr();
    chk("conflict_wb_wen", {30'd0, wb_wen}, 32'h2);
    chk("conflict_wb_rd1", {27'd0, wb_rd[RW +: RW]}, 32'd5);
    chk("conflict_wb_data1", wb_data[XLEN +: XLEN], 32'h22);
    rd0(5'd5, d); chk("conflict_reg5", d, 32'h22);

    // 3) load beats exec in the same lane
    mem_load = 2'b01; mem_rd[0 +: RW] = 5'd3; mem_doutb[0 +: XLEN] = 32'hAAAA;
    ex_wen = 2'b01; ex_rd[0 +: RW] = 5'd3; ex_data[0 +: XLEN] = 32'h1;
    tick(); clr();
    chk("loadprio_wb_wen", {30'd0, wb_wen}, 32'h1);
    rd0(5'd3, d); chk("loadprio_reg3", d, 32'hAAAA);

    // 4) load captured across a 3-cycle interlock while doutb goes to 0
    interlock = 1'b1;
    mem_load = 2'b10; mem_rd[RW +: RW] = 5'd7; mem_doutb[XLEN +: XLEN] = 32'hBEEF;
    tick();
    mem_doutb[XLEN +: XLEN] = 32'h0;
    tick();
    chk("stall_wb_wen", {30'd0, wb_wen}, 32'h0);
    rd0(5'd7, d); chk("stall_reg7_old", d, 32'h0);
    tick();
    interlock = 1'b0;
    rd0(5'd7, d); chk("release_bypass", d, 32'hBEEF);
    tick(); clr();
    rd0(5'd7, d); chk("release_reg7", d, 32'hBEEF);
    chk("release_wb_data1", wb_data[XLEN +: XLEN], 32'hBEEF);
    chk("release_wb_wen", {30'd0, wb_wen}, 32'h2);
    // hold must be released: a fresh load takes live doutb
    mem_load = 2'b10; mem_rd[RW +: RW] = 5'd7; mem_doutb[XLEN +: XLEN] = 32'h5;
    tick(); clr();
    rd0(5'd7, d); chk("hold_cleared_reg7", d, 32'h5);

    // 5) writes to r0 are suppressed
    ex_wen = 2'b01; ex_rd[0 +: RW] = 5'd0; ex_data[0 +: XLEN] = 32'hFFFF;
    rd0(5'd0, d); chk("zero_bypass", d, 32'h0);
    tick(); clr();
    chk("zero_wb_wen", {30'd0, wb_wen}, 32'h0);
    rd0(5'd0, d); chk("zero_reg0", d, 32'h0);

    // 6) write-through, and none under interlock
    ex_wen = 2'b01; ex_rd[0 +: RW] = 5'd9; ex_data[0 +: XLEN] = 32'h77;
    rd0(5'd9, d); chk("wt_bypass", d, 32'h77);
    tick();
    interlock = 1'b1; ex_data[0 +: XLEN] = 32'h99;
    rd0(5'd9, d); chk("wt_stall_old", d, 32'h77);
    tick();
    chk("wt_stall_wb_wen", {30'd0, wb_wen}, 32'h0);
    rd0(5'd9, d); chk("wt_stall_reg9", d, 32'h77);
    interlock = 1'b0; clr();

    // distinct rds in both lanes both commit; mem_wen beats ex_wen
    ex_wen = 2'b11;
    ex_rd[0 +: RW] = 5'd10;  ex_data[0 +: XLEN] = 32'hA;
    ex_rd[RW +: RW] = 5'd11; ex_data[XLEN +: XLEN] = 32'hB;
    tick(); clr();
    chk("dual_wb_wen", {30'd0, wb_wen}, 32'h3);
    rd0(5'd10, d); chk("dual_reg10", d, 32'hA);
    rd0(5'd11, d); chk("dual_reg11", d, 32'hB);
    mem_wen = 2'b10; mem_rd[RW +: RW] = 5'd12; mem_data[XLEN +: XLEN] = 32'hC;
    ex_wen = 2'b10;  ex_rd[RW +: RW] = 5'd13;  ex_data[XLEN +: XLEN] = 32'hD;
    tick(); clr();
    rd0(5'd12, d); chk("memprio_reg12", d, 32'hC);
    rd0(5'd13, d); chk("memprio_reg13", d, 32'h0);

    // reset during a stall drops the captured load
    interlock = 1'b1;
    mem_load = 2'b01; mem_rd[0 +: RW] = 5'd14; mem_doutb[0 +: XLEN] = 32'h1234;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1; interlock = 1'b0; mem_doutb[0 +: XLEN] = 32'h5678;
    tick(); clr();
    rd0(5'd14, d); chk("rststall_reg14", d, 32'h5678);
    rd0(5'd5, d);  chk("rststall_reg5", d, 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
